// File: rtl/ec_scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ec_scalar_mult_ctrl
//  Description : Left-to-right double-and-add controller computing R = k*G.
//                Every doubling and addition is issued to an external
//                point-add unit over a request/response handshake. The
//                accumulator starts at infinity, so leading zero bits and the
//                first one bit cost no adder calls.
//  Revision    : 1.0 - initial release
// ============================================================================
module ec_scalar_mult_ctrl #(
    parameter int WIDTH = 256,
    parameter int KBITS = 256
) (
    input  logic             clk,
    input  logic             rst_n,          // asynchronous, active-high
    input  logic             in_valid,
    input  logic [KBITS-1:0] k,
    input  logic [WIDTH-1:0] Gx,
    input  logic [WIDTH-1:0] Gy,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] Rx,
    output logic [WIDTH-1:0] Ry,
    output logic             r_inf,
    output logic             add_in_valid,
    output logic [WIDTH-1:0] add_Px,
    output logic [WIDTH-1:0] add_Py,
    output logic [WIDTH-1:0] add_Qx,
    output logic [WIDTH-1:0] add_Qy,
    input  logic [WIDTH-1:0] add_Rx,
    input  logic [WIDTH-1:0] add_Ry,
    input  logic             add_out_valid
);

    localparam int CNT_W = $clog2(KBITS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_DBL_REQ  = 3'd2;
    localparam logic [2:0] S_DBL_WAIT = 3'd3;
    localparam logic [2:0] S_BIT      = 3'd4;
    localparam logic [2:0] S_ADD_REQ  = 3'd5;
    localparam logic [2:0] S_ADD_WAIT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(KBITS);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q,   state_d;
    logic [KBITS-1:0] k_sh_q,    k_sh_d;
    logic [WIDTH-1:0] gx_q,      gx_d;
    logic [WIDTH-1:0] gy_q,      gy_d;
    logic [WIDTH-1:0] accx_q,    accx_d;
    logic [WIDTH-1:0] accy_q,    accy_d;
    logic             acc_inf_q, acc_inf_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             w_advance;
    logic             w_dbl_out;
    logic             w_add_out;

    // Next-state and datapath update for the double-and-add sequencer
    always_comb begin
        state_d   = state_q;
        k_sh_d    = k_sh_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        accx_d    = accx_q;
        accy_d    = accy_q;
        acc_inf_d = acc_inf_q;
        cnt_d     = cnt_q;
        w_advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    k_sh_d    = k;
                    gx_d      = Gx;
                    gy_d      = Gy;
                    accx_d    = '0;
                    accy_d    = '0;
                    acc_inf_d = 1'b1;
                    cnt_d     = C_CNT_INIT;
                    state_d   = S_SCAN;
                end
            end
            // Doubling infinity is a no-op, so skip the adder until acc is real
            S_SCAN:     state_d = acc_inf_q ? S_BIT : S_DBL_REQ;
            S_DBL_REQ:  state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (add_out_valid) begin
                    accx_d  = add_Rx;
                    accy_d  = add_Ry;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (!k_sh_q[KBITS-1]) begin
                    w_advance = 1'b1;
                end else if (acc_inf_q) begin
                    // First set bit: acc becomes G without an adder call
                    accx_d    = gx_q;
                    accy_d    = gy_q;
                    acc_inf_d = 1'b0;
                    w_advance = 1'b1;
                end else begin
                    state_d = S_ADD_REQ;
                end
            end
            S_ADD_REQ:  state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (add_out_valid) begin
                    accx_d    = add_Rx;
                    accy_d    = add_Ry;
                    w_advance = 1'b1;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (w_advance) begin
            k_sh_d  = k_sh_q << 1;
            cnt_d   = cnt_q - C_CNT_ONE;
            state_d = (cnt_q == C_CNT_ONE) ? S_DONE : S_SCAN;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            k_sh_q    <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            accx_q    <= '0;
            accy_q    <= '0;
            acc_inf_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_sh_q    <= k_sh_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            accx_q    <= accx_d;
            accy_q    <= accy_d;
            acc_inf_q <= acc_inf_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decoded from state; operand buses stay zero outside a request
    always_comb begin
        busy         = (state_q != S_IDLE);
        out_valid    = (state_q == S_DONE);
        r_inf        = out_valid & acc_inf_q;
        Rx           = (out_valid && !acc_inf_q) ? accx_q : '0;
        Ry           = (out_valid && !acc_inf_q) ? accy_q : '0;
        add_in_valid = (state_q == S_DBL_REQ) || (state_q == S_ADD_REQ);
        w_dbl_out    = (state_q == S_DBL_REQ) || (state_q == S_DBL_WAIT);
        w_add_out    = (state_q == S_ADD_REQ) || (state_q == S_ADD_WAIT);
        add_Px       = (w_dbl_out || w_add_out) ? accx_q : '0;
        add_Py       = (w_dbl_out || w_add_out) ? accy_q : '0;
        add_Qx       = w_dbl_out ? accx_q : (w_add_out ? gx_q : '0);
        add_Qy       = w_dbl_out ? accy_q : (w_add_out ? gy_q : '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_ec_scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ec_scalar_mult_ctrl
//  Description : Bench for ec_scalar_mult_ctrl with a mock point-add unit.
//                The mock either tracks points symbolically as multiples of G
//                or performs real secp256k1 arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ec_scalar_mult_ctrl;

    localparam int W = 256;

    localparam logic [W-1:0] P_FIELD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] SG_X  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [W-1:0] SG_Y  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [W-1:0] SG2_X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [W-1:0] SG2_Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
    localparam logic [W-1:0] SG3_X = 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
    localparam logic [W-1:0] SG3_Y = 256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;
    localparam logic [W-1:0] KX = {32{8'h5A}};
    localparam logic [W-1:0] KY = {32{8'hC3}};

    typedef struct {
        bit           dbl;
        logic [W-1:0] m1;
        logic [W-1:0] m2;
    } op_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] k, Gx, Gy;
    logic         busy, out_valid, r_inf, add_in_valid;
    logic [W-1:0] Rx, Ry, add_Px, add_Py, add_Qx, add_Qy;
    logic [W-1:0] add_Rx, add_Ry;
    logic         add_out_valid;

    logic         mock_ov, stray_ov;
    logic [W-1:0] mock_rx, mock_ry, stray_rx, stray_ry;
    bit           mock_real, mock_hold, held_seen;
    int           mock_lat;
    logic [W-1:0] cur_gx, cur_gy;
    op_t          ops[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign add_out_valid = mock_ov | stray_ov;
    assign add_Rx        = mock_ov ? mock_rx : stray_rx;
    assign add_Ry        = mock_ov ? mock_ry : stray_ry;

    ec_scalar_mult_ctrl #(.WIDTH(W), .KBITS(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .k(k), .Gx(Gx), .Gy(Gy),
        .busy(busy), .out_valid(out_valid), .Rx(Rx), .Ry(Ry), .r_inf(r_inf),
        .add_in_valid(add_in_valid), .add_Px(add_Px), .add_Py(add_Py),
        .add_Qx(add_Qx), .add_Qy(add_Qy), .add_Rx(add_Rx), .add_Ry(add_Ry),
        .add_out_valid(add_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // ---------------- field and curve arithmetic (secp256k1) ----------------
    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, P_FIELD}) t = t - {1'b0, P_FIELD};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, P_FIELD} - {1'b0, b};
        if (t >= {1'b0, P_FIELD}) t = t - {1'b0, P_FIELD};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] t;
        t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        t = t % {{W{1'b0}}, P_FIELD};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] finv(input logic [W-1:0] a);
        logic [W-1:0] r, b, e;
        r = 1;
        b = a;
        e = P_FIELD - 2;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = fmul(r, b);
            b = fmul(b, b);
        end
        return r;
    endfunction

    function automatic void ec_dbl(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] x3, output logic [W-1:0] y3);
        logic [W-1:0] l;
        l  = fmul(fmul(256'd3, fmul(x, x)), finv(fadd(y, y)));
        x3 = fsub(fmul(l, l), fadd(x, x));
        y3 = fsub(fmul(l, fsub(x, x3)), y);
    endfunction

    function automatic void ec_add(input logic [W-1:0] x1, input logic [W-1:0] y1,
                                   input logic [W-1:0] x2, input logic [W-1:0] y2,
                                   output logic [W-1:0] x3, output logic [W-1:0] y3);
        logic [W-1:0] l;
        l  = fmul(fsub(y2, y1), finv(fsub(x2, x1)));
        x3 = fsub(fsub(fmul(l, l), x1), x2);
        y3 = fsub(fmul(l, fsub(x1, x3)), y1);
    endfunction

    // ---------------- symbolic point encoding: m*G <-> coordinates ----------
    function automatic logic [W-1:0] enc_x(input logic [W-1:0] m);
        return m ^ KX;
    endfunction

    function automatic logic [W-1:0] enc_y(input logic [W-1:0] m);
        return m ^ KY;
    endfunction

    function automatic void decode(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] m, output bit ok);
        if (x == cur_gx && y == cur_gy) begin
            m  = 1;
            ok = 1'b1;
        end else begin
            m  = x ^ KX;
            ok = (y == enc_y(m)) && (m > 1);
        end
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- mock adder: scoreboards operands, returns results -----
    initial begin : mock_adder
        logic [W-1:0] cpx, cpy, cqx, cqy, rx, ry, m1, m2;
        bit ok1, ok2, bad;
        op_t op;
        mock_ov = 1'b0; mock_rx = '0; mock_ry = '0; held_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (add_in_valid === 1'b1) begin
                cpx = add_Px; cpy = add_Py; cqx = add_Qx; cqy = add_Qy;
                op.dbl = (cpx == cqx) && (cpy == cqy);
                op.m1 = '0;
                op.m2 = '0;
                if (mock_real) begin
                    if (op.dbl) ec_dbl(cpx, cpy, rx, ry);
                    else        ec_add(cpx, cpy, cqx, cqy, rx, ry);
                end else begin
                    decode(cpx, cpy, m1, ok1);
                    decode(cqx, cqy, m2, ok2);
                    n_checks++;
                    if (!(ok1 && ok2)) begin
                        n_fail++;
                        $display("FAIL mock_operand_decode: got P=(%h,%h) Q=(%h,%h), required known multiples of G", cpx, cpy, cqx, cqy);
                    end
                    op.m1 = m1;
                    op.m2 = m2;
                    rx = enc_x(op.dbl ? (m1 << 1) : (m1 + m2));
                    ry = enc_y(op.dbl ? (m1 << 1) : (m1 + m2));
                end
                ops.push_back(op);
                if (mock_hold && !op.dbl) begin
                    held_seen = 1'b1;
                end else begin
                    bad = 1'b0;
                    for (int i = 0; i < mock_lat; i++) begin
                        @(posedge clk); #1;
                        if (add_Px !== cpx || add_Py !== cpy || add_Qx !== cqx ||
                            add_Qy !== cqy || add_in_valid !== 1'b0) bad = 1'b1;
                    end
                    n_checks++;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL mock_operand_hold: got operands changed or repeated request, required stable operands for %0d cycles", mock_lat);
                    end
                    mock_ov = 1'b1; mock_rx = rx; mock_ry = ry;
                    @(posedge clk); #1;
                    mock_ov = 1'b0; mock_rx = '0; mock_ry = '0;
                    n_checks++;
                    if (add_Px !== '0 || add_Py !== '0 || add_Qx !== '0 || add_Qy !== '0) begin
                        n_fail++;
                        $display("FAIL operand_idle_zero: got P=(%h,..) after response, required 0", add_Px);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at #1 after a posedge) -------
    task automatic start_req(input logic [W-1:0] kk, input logic [W-1:0] gx, input logic [W-1:0] gy);
        cur_gx = gx; cur_gy = gy;
        in_valid = 1'b1; k = kk; Gx = gx; Gy = gy;
        @(posedge clk); #1;
        in_valid = 1'b0; k = rand256(); Gx = rand256(); Gy = rand256();
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit timed_out, output bit leak);
        cyc = 1; timed_out = 1'b0; leak = 1'b0;
        while (out_valid !== 1'b1) begin
            if (busy !== 1'b1 || Rx !== '0 || Ry !== '0 || r_inf !== 1'b0) leak = 1'b1;
            if (cyc >= limit) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; k = '0; Gx = '0; Gy = '0;
        stray_ov = 1'b0; stray_rx = '0; stray_ry = '0;
        mock_real = 1'b0; mock_hold = 1'b0; mock_lat = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b out_valid=%b, required 0/0", busy, out_valid);
        end
        n_checks++;
        if (Rx !== '0 || Ry !== '0 || r_inf !== 1'b0) begin
            n_fail++; $display("FAIL reset_result: got Rx=%h r_inf=%b, required 0", Rx, r_inf);
        end
        n_checks++;
        if (add_in_valid !== 1'b0 || add_Px !== '0 || add_Py !== '0 || add_Qx !== '0 || add_Qy !== '0) begin
            n_fail++; $display("FAIL reset_adder_bus: got req=%b Px=%h, required 0", add_in_valid, add_Px);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_k_zero();
        int cyc; bit to, lk;
        ops.delete();
        start_req('0, rand256(), rand256());
        wait_done(2000, cyc, to, lk);
        n_checks++;
        if (to || lk) begin n_fail++; $display("FAIL k0_progress: got timeout=%0d leak=%0d, required 0/0", to, lk); end
        n_checks++;
        if (cyc !== 513) begin n_fail++; $display("FAIL k0_latency: got %0d cycles, required 513", cyc); end
        n_checks++;
        if (r_inf !== 1'b1 || Rx !== '0 || Ry !== '0) begin
            n_fail++; $display("FAIL k0_result: got r_inf=%b Rx=%h Ry=%h, required 1/0/0", r_inf, Rx, Ry);
        end
        n_checks++;
        if (ops.size() != 0) begin n_fail++; $display("FAIL k0_adder_calls: got %0d, required 0", ops.size()); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL k0_after_done: got busy=%b out_valid=%b, required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_k_one();
        int cyc; bit to, lk;
        logic [W-1:0] gx, gy;
        gx = rand256(); gy = rand256();
        ops.delete();
        start_req(256'd1, gx, gy);
        wait_done(2000, cyc, to, lk);
        n_checks++;
        if (to || lk) begin n_fail++; $display("FAIL k1_progress: got timeout=%0d leak=%0d, required 0/0", to, lk); end
        n_checks++;
        if (Rx !== gx || Ry !== gy || r_inf !== 1'b0) begin
            n_fail++; $display("FAIL k1_result: got Rx=%h Ry=%h r_inf=%b, required G, r_inf=0", Rx, Ry, r_inf);
        end
        n_checks++;
        if (ops.size() != 0) begin n_fail++; $display("FAIL k1_adder_calls: got %0d, required 0", ops.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_k_five();
        int cyc; bit to, lk;
        int lats[2] = '{1, 37};
        foreach (lats[j]) begin
            mock_lat = lats[j];
            ops.delete();
            start_req(256'd5, rand256(), rand256());
            wait_done(5000, cyc, to, lk);
            n_checks++;
            if (to || lk) begin n_fail++; $display("FAIL k5_progress: got timeout=%0d leak=%0d, required 0/0", to, lk); end
            n_checks++;
            if (Rx !== enc_x(256'd5) || Ry !== enc_y(256'd5) || r_inf !== 1'b0) begin
                n_fail++; $display("FAIL k5_result lat=%0d: got Rx=%h, required %h", mock_lat, Rx, enc_x(256'd5));
            end
            n_checks++;
            if (ops.size() != 3) begin
                n_fail++; $display("FAIL k5_sequence: got %0d adder calls, required 3", ops.size());
            end else if (!(ops[0].dbl && ops[0].m1 == 1 && ops[0].m2 == 1 &&
                           ops[1].dbl && ops[1].m1 == 2 && ops[1].m2 == 2 &&
                           !ops[2].dbl && ops[2].m1 == 4 && ops[2].m2 == 1)) begin
                n_fail++; $display("FAIL k5_sequence: got ops (%0d,%0d)(%0d,%0d)(%0d,%0d), required DBL(1,1) DBL(2,2) ADD(4,1)",
                                   ops[0].m1, ops[0].m2, ops[1].m1, ops[1].m2, ops[2].m1, ops[2].m2);
            end
            n_checks++;
            if (cyc !== 513 + 3 * (1 + mock_lat)) begin
                n_fail++; $display("FAIL k5_latency lat=%0d: got %0d, required %0d", mock_lat, cyc, 513 + 3 * (1 + mock_lat));
            end
            @(posedge clk); #1;
        end
        mock_lat = 1;
    endtask

    task automatic test_random_k();
        int cyc; bit to, lk;
        logic [W-1:0] kk;
        int msb, pop, calls;
        for (int it = 0; it < 4; it++) begin
            kk = (it == 0) ? W'($urandom_range(2, 1000)) : rand256();
            if (kk < 2) kk = 256'd7;
            mock_lat = $urandom_range(1, 4);
            msb = 0; pop = 0;
            for (int b = 0; b < W; b++) if (kk[b]) begin msb = b; pop++; end
            calls = msb + pop - 1;
            ops.delete();
            start_req(kk, rand256(), rand256());
            wait_done(20000, cyc, to, lk);
            n_checks++;
            if (to || lk) begin n_fail++; $display("FAIL rand_progress: got timeout=%0d leak=%0d, required 0/0", to, lk); end
            n_checks++;
            if (Rx !== enc_x(kk) || Ry !== enc_y(kk) || r_inf !== 1'b0) begin
                n_fail++; $display("FAIL rand_result k=%h: got Rx=%h, required %h", kk, Rx, enc_x(kk));
            end
            n_checks++;
            if (ops.size() != calls || cyc !== 513 + calls * (1 + mock_lat)) begin
                n_fail++; $display("FAIL rand_calls k=%h: got %0d calls %0d cycles, required %0d calls %0d cycles",
                                   kk, ops.size(), cyc, calls, 513 + calls * (1 + mock_lat));
            end
            @(posedge clk); #1;
        end
        mock_lat = 1;
    endtask

    task automatic test_real_adder();
        int cyc; bit to, lk;
        logic [W-1:0] ex, ey;
        mock_real = 1'b1;
        mock_lat  = 3;
        for (int kv = 2; kv <= 3; kv++) begin
            ex = (kv == 2) ? SG2_X : SG3_X;
            ey = (kv == 2) ? SG2_Y : SG3_Y;
            ops.delete();
            start_req(W'(kv), SG_X, SG_Y);
            repeat (3) @(posedge clk);
            #1;
            in_valid = 1'b1; k = 256'd1; Gx = rand256(); Gy = rand256();
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_done(5000, cyc, to, lk);
            n_checks++;
            if (to || lk) begin n_fail++; $display("FAIL real_progress k=%0d: got timeout=%0d leak=%0d, required 0/0", kv, to, lk); end
            n_checks++;
            if (Rx !== ex || Ry !== ey || r_inf !== 1'b0) begin
                n_fail++; $display("FAIL real_result k=%0d: got Rx=%h Ry=%h, required %h %h", kv, Rx, Ry, ex, ey);
            end
            n_checks++;
            if (ops.size() != kv - 1) begin n_fail++; $display("FAIL real_calls k=%0d: got %0d, required %0d", kv, ops.size(), kv - 1); end
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL real_busy_at_done: got %b, required 1", busy); end
            @(posedge clk); #1;
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL real_busy_after_done: got busy=%b out_valid=%b, required 0/0", busy, out_valid);
            end
        end
        mock_real = 1'b0;
        mock_lat  = 1;
    endtask

    task automatic test_reset_mid_op();
        int cyc, n; bit to, lk, bad;
        logic [W-1:0] gx, gy;
        mock_lat = 2; mock_hold = 1'b1; held_seen = 1'b0;
        start_req(256'hFF, rand256(), rand256());
        n = 0;
        while (!held_seen && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!held_seen) begin n_fail++; $display("FAIL midrst_reach_add: got no ADD request in 3000 cycles, required one"); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || add_in_valid !== 1'b0 || Rx !== '0 || Ry !== '0 || r_inf !== 1'b0 ||
            add_Px !== '0 || add_Py !== '0 || add_Qx !== '0 || add_Qy !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got busy=%b out_valid=%b req=%b Px=%h, required all 0", busy, out_valid, add_in_valid, add_Px);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        stray_ov = 1'b1; stray_rx = rand256(); stray_ry = rand256();
        @(posedge clk); #1;
        stray_ov = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || out_valid !== 1'b0 || add_in_valid !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL midrst_late_response: got activity after late add_out_valid, required none"); end
        mock_hold = 1'b0; held_seen = 1'b0; mock_lat = 1;
        gx = rand256(); gy = rand256();
        start_req(256'd1, gx, gy);
        wait_done(2000, cyc, to, lk);
        n_checks++;
        if (to || lk || Rx !== gx || Ry !== gy || r_inf !== 1'b0) begin
            n_fail++; $display("FAIL midrst_next_request: got timeout=%0d Rx=%h, required %h", to, Rx, gx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stray_and_back_to_back();
        int cyc; bit to, lk;
        logic [W-1:0] k1, k2;
        stray_ov = 1'b1; stray_rx = rand256(); stray_ry = rand256();
        @(posedge clk); #1;
        stray_ov = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || add_in_valid !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: got busy=%b out_valid=%b req=%b, required 0/0/0", busy, out_valid, add_in_valid);
        end
        k1 = W'($urandom_range(2, 255));
        k2 = W'($urandom_range(2, 255));
        start_req(k1, rand256(), rand256());
        stray_ov = 1'b1; stray_rx = rand256(); stray_ry = rand256();
        @(posedge clk); #1;
        stray_ov = 1'b0;
        wait_done(5000, cyc, to, lk);
        n_checks++;
        if (to || lk || Rx !== enc_x(k1) || Ry !== enc_y(k1)) begin
            n_fail++; $display("FAIL stray_scan k=%0d: got timeout=%0d Rx=%h, required %h", k1, to, Rx, enc_x(k1));
        end
        @(posedge clk); #1;
        start_req(k2, rand256(), rand256());
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b, required 1", busy); end
        wait_done(5000, cyc, to, lk);
        n_checks++;
        if (to || lk || Rx !== enc_x(k2) || Ry !== enc_y(k2) || r_inf !== 1'b0) begin
            n_fail++; $display("FAIL b2b_result k=%0d: got timeout=%0d Rx=%h, required %h", k2, to, Rx, enc_x(k2));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_k_zero();
        test_k_one();
        test_k_five();
        test_random_k();
        test_real_adder();
        test_reset_mid_op();
        test_stray_and_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
